// File: rtl/ex_ctrl_if.sv
// Handshake and tracking signals between the ID stage, the EX control block
// and the downstream MEM/WB bookkeeping.
interface ex_ctrl_if;
    logic       id_valid;
    logic       id_ready;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       branch_taken;
    logic       mem_ready;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_is_load;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic       mem_reg_write;
    logic       wb_reg_write;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       flush;
    logic [1:0] state;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, branch_taken, mem_ready,
        input  id_ready, ex_valid, ex_rd, ex_reg_write, ex_is_load, mem_rd, wb_rd,
               mem_reg_write, wb_reg_write, fwd_a, fwd_b, flush, state
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, branch_taken, mem_ready,
        output id_ready, ex_valid, ex_rd, ex_reg_write, ex_is_load, mem_rd, wb_rd,
               mem_reg_write, wb_reg_write, fwd_a, fwd_b, flush, state
    );
endinterface

// File: rtl/ex_ctrl.sv
// EX-stage pipeline control: ID handshake, load-use stall, branch flush,
// MEM/WB destination tracking and operand forwarding selection.
module ex_ctrl (
    input logic     clk,
    input logic     rst,
    ex_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       ex_valid_q;
    logic [4:0] ex_rd_q;
    logic [4:0] ex_rs1_q;
    logic [4:0] ex_rs2_q;
    logic       ex_reg_write_q;
    logic       ex_is_load_q;
    logic [4:0] mem_rd_q;
    logic       mem_reg_write_q;
    logic [4:0] wb_rd_q;
    logic       wb_reg_write_q;

    logic       ex_adv;
    logic       load_use;
    logic       take;
    logic       id_ready;
    logic       transfer;
    logic       flush;

    function automatic logic decode_reg_write(input logic [6:0] opcode, input logic [4:0] rd);
        logic writes;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: writes = 1'b1;
            default:                            writes = 1'b0;
        endcase
        return writes && (rd != 5'd0);
    endfunction

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic valid,
                                           input logic m_we, input logic [4:0] m_rd,
                                           input logic w_we, input logic [4:0] w_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (valid && src != 5'd0) begin
            if (m_we && m_rd == src)
                sel = 2'b01;
            else if (w_we && w_rd == src)
                sel = 2'b10;
        end
        return sel;
    endfunction

    assign ex_adv   = !ex_valid_q || bus.mem_ready;
    assign load_use = ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) &&
                      ((ex_rd_q == bus.id_rs1) || (ex_rd_q == bus.id_rs2));
    assign take     = ex_valid_q && bus.branch_taken && ex_adv;
    assign transfer = bus.id_valid && id_ready && !take && (state_q != FLUSH);

    always_comb begin
        state_d  = state_q;
        id_ready = 1'b0;
        flush    = 1'b0;
        if (!rst) begin
            id_ready = take || (state_q == FLUSH) || (ex_adv && !load_use);
            flush    = (state_q == FLUSH);
        end
        if (take)
            state_d = FLUSH;
        else if (state_q == RUN && load_use && ex_adv)
            state_d = STALL;
        else
            state_d = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // EX stage: load on transfer, otherwise bubble whenever the slot advances
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= 5'd0;
            ex_reg_write_q <= 1'b0;
            ex_is_load_q   <= 1'b0;
        end else if (transfer) begin
            ex_valid_q     <= 1'b1;
            ex_rd_q        <= bus.id_rd;
            ex_reg_write_q <= decode_reg_write(bus.id_opcode, bus.id_rd);
            ex_is_load_q   <= (bus.id_opcode == 7'b0000011);
        end else if (ex_adv) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_is_load_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (transfer) begin
            ex_rs1_q <= bus.id_rs1;
            ex_rs2_q <= bus.id_rs2;
        end
    end

    // MEM stage tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_q        <= 5'd0;
            mem_reg_write_q <= 1'b0;
        end else if (ex_adv) begin
            mem_rd_q        <= ex_rd_q;
            mem_reg_write_q <= ex_valid_q && ex_reg_write_q;
        end
    end

    // WB stage tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
        end else if (bus.mem_ready) begin
            wb_rd_q        <= mem_rd_q;
            wb_reg_write_q <= mem_reg_write_q;
        end
    end

    assign bus.id_ready      = id_ready;
    assign bus.flush         = flush;
    assign bus.state         = state_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.ex_reg_write  = ex_reg_write_q;
    assign bus.ex_is_load    = ex_is_load_q;
    assign bus.mem_rd        = mem_rd_q;
    assign bus.mem_reg_write = mem_reg_write_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_reg_write  = wb_reg_write_q;
    assign bus.fwd_a = fwd_sel(ex_rs1_q, ex_valid_q, mem_reg_write_q, mem_rd_q,
                               wb_reg_write_q, wb_rd_q);
    assign bus.fwd_b = fwd_sel(ex_rs2_q, ex_valid_q, mem_reg_write_q, mem_rd_q,
                               wb_reg_write_q, wb_rd_q);
endmodule
